// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-port SRAM arbiter.
package sram_arb_pkg;

  localparam int unsigned DefAw   = 32;
  localparam int unsigned DefDw   = 32;
  // Wide enough for MAX_D_STREAK up to 15 and WR_TURN up to 3.
  localparam int unsigned StreakW = 4;
  localparam int unsigned TurnW   = 2;

  typedef enum logic [0:0] {
    READY,
    TURN
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_I,
    GNT_D
  } gnt_src_e;

endpackage

// File: rtl/arb_streak_ctr.sv
// Saturating count of consecutive D grants taken while fetch was waiting.
// o_sat flags that fetch must be granted next time both sides compete.
module arb_streak_ctr
  import sram_arb_pkg::*;
#(
  parameter int unsigned Limit = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_sat
);

  localparam logic [StreakW-1:0] LimitW = StreakW'(Limit);

  logic [StreakW-1:0] r_count;

  // Clear wins over increment; the count sticks at the limit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LimitW)) begin
      r_count <= r_count + StreakW'(1);
    end
  end

  assign o_sat = (r_count == LimitW);

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch (I) and
// load/store (D). Data side has priority, bounded by a starvation limit for
// fetch; every write is followed by WR_TURN dead cycles. Read data returns one
// cycle after the grant. Define SRAM_ARB_STATS_EN to add activity counters.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned AW           = DefAw,
  parameter int unsigned DW           = DefDw,
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned WR_TURN      = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_cs,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_conflicts,
  output logic [31:0]   stat_forced_i,
  output logic [31:0]   stat_turn
`endif
);

  arb_state_e          r_state;
  logic [TurnW-1:0]    r_turn_cnt;
  logic                r_i_rvalid;
  logic                r_d_rvalid;
  logic [DW-1:0]       r_i_rdata;
  logic [DW-1:0]       r_d_rdata;
  gnt_src_e            w_gnt_src;
  logic                w_sat;
  logic                w_d_rd;

  // Grant decision: D first unless fetch has waited out its streak budget.
  always_comb begin
    w_gnt_src = GNT_NONE;
    if (r_state == READY) begin
      if (i_req && (!d_req || w_sat)) begin
        w_gnt_src = GNT_I;
      end else if (d_req) begin
        w_gnt_src = GNT_D;
      end
    end
  end

  assign i_gnt  = (w_gnt_src == GNT_I);
  assign d_gnt  = (w_gnt_src == GNT_D);
  assign w_d_rd = d_gnt && !d_we;

  arb_streak_ctr #(
    .Limit (MAX_D_STREAK)
  ) u_streak (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (d_gnt && i_req),
    .i_clr (!i_req || i_gnt),
    .o_sat (w_sat)
  );

  // SRAM strobes follow the winner; bus is driven to zero when idle.
  always_comb begin
    mem_cs   = 1'b0;
    mem_oe   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (i_gnt) begin
      mem_cs   = 1'b1;
      mem_oe   = 1'b1;
      mem_addr = i_addr;
    end else if (d_gnt) begin
      mem_cs   = 1'b1;
      mem_addr = d_addr;
      if (d_we) begin
        mem_we  = 1'b1;
        mem_din = d_wdata;
      end else begin
        mem_oe = 1'b1;
      end
    end
  end

  // State, turnaround countdown and read-return capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= READY;
      r_turn_cnt <= '0;
      r_i_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_i_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_i_rvalid <= i_gnt;
      r_d_rvalid <= w_d_rd;
      if (i_gnt) r_i_rdata <= mem_dout;
      if (w_d_rd) r_d_rdata <= mem_dout;
      unique case (r_state)
        READY: begin
          if (d_gnt && d_we && (WR_TURN != 0)) begin
            r_state    <= TURN;
            r_turn_cnt <= TurnW'(WR_TURN);
          end
        end
        TURN: begin
          r_turn_cnt <= r_turn_cnt - TurnW'(1);
          if (r_turn_cnt == TurnW'(1)) r_state <= READY;
        end
        default: r_state <= READY;
      endcase
    end
  end

  assign i_rvalid = r_i_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign i_rdata  = r_i_rdata;
  assign d_rdata  = r_d_rdata;

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] r_stat_conflicts;
  logic [31:0] r_stat_forced_i;
  logic [31:0] r_stat_turn;

  // Free-running activity counters; wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_conflicts <= '0;
      r_stat_forced_i  <= '0;
      r_stat_turn      <= '0;
    end else begin
      if (r_state == READY && i_req && d_req) r_stat_conflicts <= r_stat_conflicts + 32'd1;
      if (r_state == READY && i_req && d_req && w_sat) r_stat_forced_i <= r_stat_forced_i + 32'd1;
      if (r_state == TURN) r_stat_turn <= r_stat_turn + 32'd1;
    end
  end

  assign stat_conflicts = r_stat_conflicts;
  assign stat_forced_i  = r_stat_forced_i;
  assign stat_turn      = r_stat_turn;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed vectors, a per-cycle reference model
// of the arbitration rules, and a second instance built with WR_TURN=0.
module tb_sram_port_arbiter;

  localparam int unsigned MaxStreak = 4;
  localparam int unsigned WrTurn    = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // Main instance (WR_TURN=1)
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_cs, mem_oe, mem_we;
  logic [31:0] mem_addr, mem_din, mem_dout;

  // Second instance (WR_TURN=0)
  logic        z_i_req, z_i_gnt, z_i_rvalid;
  logic [31:0] z_i_addr, z_i_rdata;
  logic        z_d_req, z_d_we, z_d_gnt, z_d_rvalid;
  logic [31:0] z_d_addr, z_d_wdata, z_d_rdata;
  logic        z_mem_cs, z_mem_oe, z_mem_we;
  logic [31:0] z_mem_addr, z_mem_din, z_mem_dout;

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_conflicts, stat_forced_i, stat_turn;
  logic [31:0] z_stat_conflicts, z_stat_forced_i, z_stat_turn;
`endif

  sram_port_arbiter #(
    .AW (32), .DW (32), .MAX_D_STREAK (MaxStreak), .WR_TURN (WrTurn)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .i_req (i_req), .i_addr (i_addr), .i_gnt (i_gnt), .i_rvalid (i_rvalid), .i_rdata (i_rdata),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata), .d_gnt (d_gnt),
    .d_rvalid (d_rvalid), .d_rdata (d_rdata),
    .mem_cs (mem_cs), .mem_oe (mem_oe), .mem_we (mem_we), .mem_addr (mem_addr),
    .mem_din (mem_din), .mem_dout (mem_dout)
`ifdef SRAM_ARB_STATS_EN
    , .stat_conflicts (stat_conflicts), .stat_forced_i (stat_forced_i), .stat_turn (stat_turn)
`endif
  );

  sram_port_arbiter #(
    .AW (32), .DW (32), .MAX_D_STREAK (MaxStreak), .WR_TURN (0)
  ) dut0 (
    .clk (clk), .rst_n (rst_n),
    .i_req (z_i_req), .i_addr (z_i_addr), .i_gnt (z_i_gnt), .i_rvalid (z_i_rvalid),
    .i_rdata (z_i_rdata),
    .d_req (z_d_req), .d_we (z_d_we), .d_addr (z_d_addr), .d_wdata (z_d_wdata),
    .d_gnt (z_d_gnt), .d_rvalid (z_d_rvalid), .d_rdata (z_d_rdata),
    .mem_cs (z_mem_cs), .mem_oe (z_mem_oe), .mem_we (z_mem_we), .mem_addr (z_mem_addr),
    .mem_din (z_mem_din), .mem_dout (z_mem_dout)
`ifdef SRAM_ARB_STATS_EN
    , .stat_conflicts (z_stat_conflicts), .stat_forced_i (z_stat_forced_i),
    .stat_turn (z_stat_turn)
`endif
  );

  // SRAM behind the main instance: word at byte address a preloads to 0x1000_0000 | a.
  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  assign mem_dout   = mem[mem_addr[9:2]];
  assign z_mem_dout = 32'h1000_0000 | z_mem_addr;
  always @(posedge clk) if (mem_cs && mem_we) mem[mem_addr[9:2]] <= mem_din;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: dead cycles remaining after a write, and how many D grants
  // fetch has watched go by in a row.
  bit          chk_en = 1'b0;
  int          m_dead, m_streak, m_g;  // m_g: 0 none, 1 I, 2 D
  bit          m_i_rv, m_d_rv;
  logic [31:0] m_i_rd, m_d_rd;

  always @(negedge clk) begin
    if (chk_en) begin
      if (m_dead > 0) m_g = 0;
      else if (i_req && d_req) m_g = (m_streak >= int'(MaxStreak)) ? 1 : 2;
      else if (i_req) m_g = 1;
      else if (d_req) m_g = 2;
      else m_g = 0;
      check("i_gnt", 32'(i_gnt), 32'(m_g == 1));
      check("d_gnt", 32'(d_gnt), 32'(m_g == 2));
      check("mem_cs", 32'(mem_cs), 32'(m_g != 0));
      check("mem_oe", 32'(mem_oe), 32'(m_g == 1 || (m_g == 2 && !d_we)));
      check("mem_we", 32'(mem_we), 32'(m_g == 2 && d_we));
      check("mem_addr", mem_addr, (m_g == 1) ? i_addr : (m_g == 2) ? d_addr : 32'h0);
      check("mem_din", mem_din, (m_g == 2 && d_we) ? d_wdata : 32'h0);
      check("i_rvalid", 32'(i_rvalid), 32'(m_i_rv));
      check("d_rvalid", 32'(d_rvalid), 32'(m_d_rv));
      check("i_rdata", i_rdata, m_i_rd);
      check("d_rdata", d_rdata, m_d_rd);
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_dead = 0; m_streak = 0; m_g = 0;
      m_i_rv = 1'b0; m_d_rv = 1'b0; m_i_rd = '0; m_d_rd = '0;
      chk_en = 1'b1;
    end else if (chk_en) begin
      m_i_rv = (m_g == 1);
      m_d_rv = (m_g == 2 && !d_we);
      if (m_i_rv) m_i_rd = shadow[i_addr[9:2]];
      if (m_d_rv) m_d_rd = shadow[d_addr[9:2]];
      if (m_g == 2 && d_we) begin
        shadow[d_addr[9:2]] = d_wdata;
        m_dead = int'(WrTurn);
      end else if (m_dead > 0) begin
        m_dead--;
      end
      if (m_g == 2 && i_req) m_streak = (m_streak + 1 > int'(MaxStreak)) ? int'(MaxStreak) : m_streak + 1;
      else if (!i_req || m_g == 1) m_streak = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq_c [6];  // {i_gnt, d_gnt} per cycle
  logic [1:0] seq_r [5];

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem[k]    = 32'h1000_0000 | (32'(k) << 2);
      shadow[k] = mem[k];
    end
    seq_c = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    seq_r = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
    rst_n = 1'b0;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    z_i_req = 1'b0; z_i_addr = '0; z_d_req = 1'b0; z_d_we = 1'b0; z_d_addr = '0; z_d_wdata = '0;

    // Reset held two cycles with a fetch pending: nothing returns.
    step(); step();
    check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
    rst_n = 1'b1;
    step();
    i_req = 1'b0;
    @(negedge clk);
    check("rst_rel_i_rvalid", 32'(i_rvalid), 32'h1);
    check("rst_rel_i_rdata", i_rdata, 32'h1000_0010);

    // Fetch-only stream at 0, 4, 8.
    step();
    i_req = 1'b1; i_addr = 32'h0; step();
    i_addr = 32'h4; step();
    i_addr = 32'h8; step();
    i_req = 1'b0;
    @(negedge clk);
    check("istream_rvalid", 32'(i_rvalid), 32'h1);
    check("istream_rdata", i_rdata, 32'h1000_0008);

    // Contention with D reads: four D grants, forced I, then D again.
    step();
    i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("contend_gnt[%0d]", c), 32'({i_gnt, d_gnt}), 32'(seq_c[c]));
      step();
    end
`ifdef SRAM_ARB_STATS_EN
    check("stat_forced_i", stat_forced_i, 32'd1);
`endif
    i_req = 1'b0; d_req = 1'b0;
    step();

    // Write 0x40 then read it back across one turnaround cycle.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("wr_gnt", 32'(d_gnt), 32'h1);
    step();
    d_we = 1'b0; d_wdata = '0;
    @(negedge clk);
    check("turn_gnt", 32'(d_gnt), 32'h0);
    check("turn_cs", 32'(mem_cs), 32'h0);
    check("wr_no_rvalid", 32'(d_rvalid), 32'h0);
    step();
    @(negedge clk);
    check("rd_after_turn_gnt", 32'(d_gnt), 32'h1);
    step();
    d_req = 1'b0;
    @(negedge clk);
    check("rd_after_wr_rvalid", 32'(d_rvalid), 32'h1);
    check("rd_after_wr_rdata", d_rdata, 32'hDEAD_BEEF);

    // WR_TURN=0 instance: write then fetch in the very next cycle.
    step();
    z_d_req = 1'b1; z_d_we = 1'b1; z_d_addr = 32'h80; z_d_wdata = 32'h1234_5678;
    @(negedge clk);
    check("z_wr_gnt", 32'(z_d_gnt), 32'h1);
    check("z_wr_din", z_mem_din, 32'h1234_5678);
    step();
    z_d_req = 1'b0; z_d_we = 1'b0; z_i_req = 1'b1; z_i_addr = 32'h44;
    @(negedge clk);
    check("z_i_gnt_next", 32'(z_i_gnt), 32'h1);
    check("z_i_oe", 32'(z_mem_oe), 32'h1);
    check("z_wr_no_rvalid", 32'(z_d_rvalid), 32'h0);
    step();
    z_i_req = 1'b0;
    @(negedge clk);
    check("z_i_rvalid", 32'(z_i_rvalid), 32'h1);
    check("z_i_rdata", z_i_rdata, 32'h1000_0044);

    // Reset landing on a D read grant mid-streak.
    step();
    i_req = 1'b1; i_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    step(); step();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_d_gnt", 32'(d_gnt), 32'h1);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_no_rvalid", 32'(d_rvalid), 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      check($sformatf("rst_mid_gnt[%0d]", c), 32'({i_gnt, d_gnt}), 32'(seq_r[c]));
      step();
    end
    i_req = 1'b0; d_req = 1'b0;
    step(); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
